// File: rtl/fft8_in_buf.sv
// rtl/fft8_in_buf.sv - ping-pong 8-sample framing buffer ahead of the 8-point FFT core
// Build option FFT8_IBUF_BITREV_EN: sample k of a frame lands in lane bitrev3(k) instead of lane k.
module fft8_in_buf #(
  parameter int DW = 24,
  parameter int N  = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_real,
  input  logic [DW-1:0]   s_imag,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N*DW-1:0] m_real,
  output logic [N*DW-1:0] m_imag,
  output logic            m_err
);

  // The 3-bit write index and lane mapping only describe an 8-point frame.
  if (N != 8) begin : g_bad_n
    $error("fft8_in_buf: N must be 8");
  end

  logic [N*DW-1:0] bank_re [2];
  logic [N*DW-1:0] bank_im [2];
  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic            wr_bank;
  logic            rd_bank;
  logic [2:0]      wr_idx;
  logic [2:0]      lane;
  logic            s_fire;
  logic            m_fire;

  // A bank is writable only while it holds no completed frame; no input feeds the handshakes.
  assign s_ready = ~full[wr_bank];
  assign m_valid = full[rd_bank];
  assign m_real  = bank_re[rd_bank];
  assign m_imag  = bank_im[rd_bank];
  assign s_fire  = s_valid & s_ready;
  assign m_fire  = m_valid & m_ready;

`ifdef FFT8_IBUF_BITREV_EN
  assign lane = {wr_idx[0], wr_idx[1], wr_idx[2]};
`else
  assign lane = wr_idx;
`endif

  // Completion and frame hand-off always touch different banks, so both can apply at once.
  always_comb begin
    full_nxt = full;
    if (m_fire) full_nxt[rd_bank] = 1'b0;
    if (s_fire && wr_idx == 3'd7) full_nxt[wr_bank] = 1'b1;
  end

  // Sample storage: flush leaves contents alone, only reset zeroes them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_re[0] <= '0;
      bank_re[1] <= '0;
      bank_im[0] <= '0;
      bank_im[1] <= '0;
    end else if (!clr && s_fire) begin
      bank_re[wr_bank][lane*DW +: DW] <= s_real;
      bank_im[wr_bank][lane*DW +: DW] <= s_imag;
    end
  end

  // Framing control: bank occupancy, bank pointers, write index and the framing-error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      m_err   <= 1'b0;
    end else if (clr) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      m_err   <= 1'b0;
    end else begin
      full  <= full_nxt;
      // An early s_last drops the partial frame; lane 7 always completes regardless of s_last.
      m_err <= s_fire & s_last & (wr_idx != 3'd7);
      if (m_fire) rd_bank <= ~rd_bank;
      if (s_fire) begin
        if (wr_idx == 3'd7) begin
          wr_bank <= ~wr_bank;
          wr_idx  <= '0;
        end else if (s_last) begin
          wr_idx <= '0;
        end else begin
          wr_idx <= wr_idx + 3'd1;
        end
      end
    end
  end

endmodule
